// File: rtl/abr_be_ram_arb_ctrl.sv
// Two-client round-robin arbiter plus zeroize sweep in front of a 1R1W byte-enable RAM.
// Grants are combinational (0 cycles), read data valid 1 cycle after grant, no backpressure; clear blocks clients for DEPTH cycles.
module abr_be_ram_arb_ctrl #(
   parameter int DEPTH        = 64,
   parameter int DATA_WIDTH   = 32,
   parameter int STROBE_WIDTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int NB = DATA_WIDTH / STROBE_WIDTH
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       zeroize_i,
   output logic                       busy_o,
   input  logic [1:0]                 wr_req_i,
   output logic [1:0]                 wr_gnt_o,
   input  logic [1:0][AW-1:0]         wr_addr_i,
   input  logic [1:0][NB-1:0]         wr_strobe_i,
   input  logic [1:0][DATA_WIDTH-1:0] wr_data_i,
   input  logic [1:0]                 rd_req_i,
   output logic [1:0]                 rd_gnt_o,
   input  logic [1:0][AW-1:0]         rd_addr_i,
   output logic [1:0]                 rd_valid_o,
   output logic [DATA_WIDTH-1:0]      rd_data_o,
   output logic                       ram_we_o,
   output logic [NB-1:0]              ram_wstrobe_o,
   output logic [AW-1:0]              ram_waddr_o,
   output logic [DATA_WIDTH-1:0]      ram_wdata_o,
   output logic                       ram_re_o,
   output logic [AW-1:0]              ram_raddr_o,
   input  logic [DATA_WIDTH-1:0]      ram_rdata_i
);

   typedef enum logic {IDLE, CLEAR} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [1:0]    rd_valid_q, rd_valid_d;

   // ptr selects the winner only on contention; a lone requester always wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
      logic [1:0] gnt;
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
      return gnt;
   endfunction

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      wr_gnt_o      = 2'b00;
      rd_gnt_o      = 2'b00;
      ram_we_o      = 1'b0;
      ram_wstrobe_o = '0;
      ram_waddr_o   = '0;
      ram_wdata_o   = '0;
      ram_re_o      = 1'b0;
      ram_raddr_o   = '0;

      case (state_q)
         IDLE: begin
            wr_gnt_o = rr_pick(wr_req_i, wr_ptr_q);
            rd_gnt_o = rr_pick(rd_req_i, rd_ptr_q);
            if (zeroize_i) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            ram_we_o      = 1'b1;
            ram_wstrobe_o = '1;
            ram_waddr_o   = cnt_q;
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (wr_gnt_o[0]) begin
         ram_we_o      = 1'b1;
         ram_wstrobe_o = wr_strobe_i[0];
         ram_waddr_o   = wr_addr_i[0];
         ram_wdata_o   = wr_data_i[0];
         wr_ptr_d      = 1'b1;
      end else if (wr_gnt_o[1]) begin
         ram_we_o      = 1'b1;
         ram_wstrobe_o = wr_strobe_i[1];
         ram_waddr_o   = wr_addr_i[1];
         ram_wdata_o   = wr_data_i[1];
         wr_ptr_d      = 1'b0;
      end

      if (rd_gnt_o[0]) begin
         ram_re_o    = 1'b1;
         ram_raddr_o = rd_addr_i[0];
         rd_ptr_d    = 1'b1;
      end else if (rd_gnt_o[1]) begin
         ram_re_o    = 1'b1;
         ram_raddr_o = rd_addr_i[1];
         rd_ptr_d    = 1'b0;
      end

      rd_valid_d = rd_gnt_o;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         rd_valid_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign busy_o     = (state_q == CLEAR);
   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = ram_rdata_i;

endmodule

// File: tb/tb_abr_be_ram_arb_ctrl.sv
// Directed bench for abr_be_ram_arb_ctrl with a behavioural byte-enable RAM behind it.
module tb_abr_be_ram_arb_ctrl;
   localparam int DEPTH = 64;
   localparam int DW    = 32;
   localparam int AW    = 6;
   localparam int NB    = 4;

   logic                clk = 1'b0;
   logic                rst_i, zeroize_i, busy_o;
   logic [1:0]          wr_req_i, wr_gnt_o, rd_req_i, rd_gnt_o, rd_valid_o;
   logic [1:0][AW-1:0]  wr_addr_i, rd_addr_i;
   logic [1:0][NB-1:0]  wr_strobe_i;
   logic [1:0][DW-1:0]  wr_data_i;
   logic [DW-1:0]       rd_data_o, ram_wdata_o, ram_rdata_i;
   logic                ram_we_o, ram_re_o;
   logic [NB-1:0]       ram_wstrobe_o;
   logic [AW-1:0]       ram_waddr_o, ram_raddr_o;

   int vectors = 0;
   int miscompares = 0;

   logic [DW-1:0] mem [DEPTH];

   always #5 clk = ~clk;

   abr_be_ram_arb_ctrl dut (
      .clk_i(clk), .rst_i(rst_i), .zeroize_i(zeroize_i), .busy_o(busy_o),
      .wr_req_i(wr_req_i), .wr_gnt_o(wr_gnt_o), .wr_addr_i(wr_addr_i),
      .wr_strobe_i(wr_strobe_i), .wr_data_i(wr_data_i),
      .rd_req_i(rd_req_i), .rd_gnt_o(rd_gnt_o), .rd_addr_i(rd_addr_i),
      .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
      .ram_we_o(ram_we_o), .ram_wstrobe_o(ram_wstrobe_o), .ram_waddr_o(ram_waddr_o),
      .ram_wdata_o(ram_wdata_o), .ram_re_o(ram_re_o), .ram_raddr_o(ram_raddr_o),
      .ram_rdata_i(ram_rdata_i)
   );

   // RAM macro model: registered read returns pre-write contents on a same-address collision.
   always @(posedge clk) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         ram_rdata_i <= '0;
      end else begin
         if (ram_re_o) ram_rdata_i <= mem[ram_raddr_o];
         if (ram_we_o)
            for (int b = 0; b < NB; b++)
               if (ram_wstrobe_o[b]) mem[ram_waddr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      zeroize_i   = 1'b0;
      wr_req_i    = 2'b00;
      rd_req_i    = 2'b00;
      wr_addr_i   = '0;
      rd_addr_i   = '0;
      wr_strobe_i = '0;
      wr_data_i   = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_i = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   logic [1:0] exp_wr [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
   logic [1:0] exp_rd [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};

   initial begin
      rst_i = 1'b1;
      idle_inputs();
      do_reset();
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_rd_valid", rd_valid_o, 0);
      check("rst_comb_idle", {wr_gnt_o, rd_gnt_o, ram_we_o, ram_re_o}, 0);

      // Partial-strobe write by c0, then read by c1.
      @(negedge clk);
      wr_req_i = 2'b01; wr_addr_i[0] = 6'd5; wr_strobe_i[0] = 4'b0011; wr_data_i[0] = 32'hAABBCCDD;
      #1;
      check("wr1_gnt", wr_gnt_o, 2'b01);
      check("wr1_port", {ram_we_o, ram_wstrobe_o, ram_waddr_o, ram_wdata_o},
            {1'b1, 4'b0011, 6'd5, 32'hAABBCCDD});
      @(negedge clk);
      idle_inputs();
      rd_req_i = 2'b10; rd_addr_i[1] = 6'd5;
      #1;
      check("rd1_gnt", {rd_gnt_o, ram_re_o, ram_raddr_o}, {2'b10, 1'b1, 6'd5});
      @(negedge clk);
      idle_inputs();
      #1;
      check("rd1_data", {rd_valid_o, rd_data_o}, {2'b10, 32'h0000CCDD});
      @(negedge clk);
      #1;
      check("rd1_valid_drop", rd_valid_o, 2'b00);

      // Round-robin: writes start one cycle ahead of reads so the two pointers differ.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         wr_req_i = 2'b11;
         rd_req_i = (i == 0) ? 2'b00 : 2'b11;
         #1;
         check("rr_wr_gnt", wr_gnt_o, exp_wr[i]);
         check("rr_rd_gnt", rd_gnt_o, exp_rd[i]);
      end

      // Same-cycle read/write collision at address 3.
      @(negedge clk);
      idle_inputs();
      wr_req_i = 2'b01; wr_addr_i[0] = 6'd3; wr_strobe_i[0] = 4'hF; wr_data_i[0] = 32'h22222222;
      @(negedge clk);
      idle_inputs();
      wr_req_i = 2'b10; wr_addr_i[1] = 6'd3; wr_strobe_i[1] = 4'hF; wr_data_i[1] = 32'h11111111;
      rd_req_i = 2'b01; rd_addr_i[0] = 6'd3;
      #1;
      check("coll_gnts", {wr_gnt_o, rd_gnt_o}, {2'b10, 2'b01});
      @(negedge clk);
      idle_inputs();
      rd_req_i = 2'b01; rd_addr_i[0] = 6'd3;
      #1;
      check("coll_old", {rd_valid_o, rd_data_o}, {2'b01, 32'h22222222});
      @(negedge clk);
      idle_inputs();
      #1;
      check("coll_new", {rd_valid_o, rd_data_o}, {2'b01, 32'h11111111});

      // Zeroize with all requests held; c1 read granted in the zeroize cycle.
      @(negedge clk);
      zeroize_i = 1'b1;
      wr_req_i = 2'b11; rd_req_i = 2'b11;
      rd_addr_i[1] = 6'd3;
      #1;
      check("zc_gnts", {busy_o, wr_gnt_o, rd_gnt_o}, {1'b0, 2'b01, 2'b10});
      @(negedge clk);
      zeroize_i = 1'b0;
      #1;
      check("clr_first", {busy_o, wr_gnt_o, rd_gnt_o, ram_re_o, ram_we_o, ram_wstrobe_o, ram_waddr_o},
            {1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 4'hF, 6'd0});
      check("clr_wdata", ram_wdata_o, 0);
      check("zc_read_done", {rd_valid_o, rd_data_o}, {2'b10, 32'h11111111});
      for (int k = 2; k <= DEPTH; k++) begin
         @(negedge clk);
         zeroize_i = (k == 10);
         #1;
         check("clr_cycle", {busy_o, wr_gnt_o, rd_gnt_o, ram_re_o, ram_we_o, ram_waddr_o},
               {1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 6'(k - 1)});
      end
      @(negedge clk);
      zeroize_i = 1'b0;
      #1;
      check("clr_resume", {busy_o, wr_gnt_o, rd_gnt_o}, {1'b0, 2'b10, 2'b01});
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         idle_inputs();
         rd_req_i = 2'b01; rd_addr_i[0] = 6'(i);
         #1;
         check("clr_readback", {rd_valid_o, rd_data_o}, {2'b01, 32'h0});
      end
      @(negedge clk);
      idle_inputs();
      #1;
      check("clr_readback_last", {rd_valid_o, rd_data_o}, {2'b01, 32'h0});

      // Reset at clear counter 10, then a full clear.
      @(negedge clk);
      zeroize_i = 1'b1; wr_req_i = 2'b01; rd_req_i = 2'b01;
      #1;
      check("rz_gnts", {wr_gnt_o, rd_gnt_o}, {2'b01, 2'b01});
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         idle_inputs();
         if (k == 11) rst_i = 1'b1;
         #1;
      end
      check("rz_cnt10", {busy_o, ram_waddr_o}, {1'b1, 6'd10});
      @(negedge clk);
      rst_i = 1'b0;
      wr_req_i = 2'b11; rd_req_i = 2'b11;
      #1;
      check("rz_after_rst", {busy_o, rd_valid_o, wr_gnt_o, rd_gnt_o}, {1'b0, 2'b00, 2'b01, 2'b01});
      @(negedge clk);
      idle_inputs();
      zeroize_i = 1'b1;
      #1;
      check("rz2_start", busy_o, 0);
      for (int k = 1; k <= DEPTH; k++) begin
         @(negedge clk);
         zeroize_i = 1'b0;
         #1;
         check("rz2_busy", {busy_o, ram_waddr_o}, {1'b1, 6'(k - 1)});
      end
      @(negedge clk);
      #1;
      check("rz2_done", busy_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/abr_be_ram_arb_ctrl.md
# abr_be_ram_arb_ctrl

Two-client arbiter and zeroize sequencer in front of a single 1R1W byte-enable RAM (one write port, one read port, registered read data). Write and read ports are arbitrated independently with round-robin fairness. A zeroize request sweeps the whole array to zero while clients are blocked. It sits between the engine datapaths that share a working buffer and the RAM macro.

## Interface
Parameters:
- DEPTH, 64, RAM words
- DATA_WIDTH, 32, word width in bits
- STROBE_WIDTH, 8, bits per write-strobe lane
- Derived: AW = $clog2(DEPTH), NB = DATA_WIDTH/STROBE_WIDTH

Ports (c = client 0/1, packed [1:0] arrays):
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- zeroize_i  in  1  start array clear (pulse or level, sampled in IDLE)
- busy_o  out  1  clear in progress
- wr_req_i  in  [1:0]  write request per client
- wr_gnt_o  out  [1:0]  write grant; combinational, one-hot or zero
- wr_addr_i  in  [1:0][AW]  write address
- wr_strobe_i  in  [1:0][NB]  write lane enables
- wr_data_i  in  [1:0][DATA_WIDTH]  write data
- rd_req_i  in  [1:0]  read request per client
- rd_gnt_o  out  [1:0]  read grant; combinational, one-hot or zero
- rd_addr_i  in  [1:0][AW]  read address
- rd_valid_o  out  [1:0]  read data valid for client c
- rd_data_o  out  DATA_WIDTH  read data (shared bus)
- ram_we_o, ram_wstrobe_o[NB], ram_waddr_o[AW], ram_wdata_o[DATA_WIDTH]  out  RAM write port
- ram_re_o, ram_raddr_o[AW]  out  RAM read port
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after ram_re_o

## Operation
- FSM states: IDLE, CLEAR. Reset -> IDLE.
- IDLE: zeroize_i=1 -> CLEAR next cycle, clear counter = 0. The zeroize cycle itself still arbitrates normally.
- CLEAR: ram_we_o=1, ram_wstrobe_o all ones, ram_wdata_o=0, ram_waddr_o=counter; counter increments each cycle. When counter=DEPTH-1, go to IDLE. Non-power-of-2 DEPTH never addresses beyond DEPTH-1. zeroize_i is ignored in CLEAR. All wr_gnt_o/rd_gnt_o = 0 and ram_re_o = 0.
- Write arbitration (IDLE): one requester gets the grant. If both request, the client selected by wr_ptr wins. After any write grant to client k, wr_ptr = ~k. Muxes client k's addr/strobe/data to the RAM with ram_we_o=1. A grant with an all-zero strobe is legal and writes nothing.
- Read arbitration: identical scheme with an independent rd_ptr. Grant drives ram_re_o=1 and ram_raddr_o.
- Requesters hold req and payload stable until the grant is seen. A grant completes the transaction in that cycle.
- rd_valid_o[c] is a register, set the cycle after rd_gnt_o[c]. rd_data_o = ram_rdata_i (pass-through).
- Same-cycle read and write to the same address: read returns the old contents. Write at cycle T is visible to a read granted at T+1 or later.

## Timing
- Reset values: busy_o=0, rd_valid_o=0, wr_ptr=rd_ptr=0 (client 0 favoured), counter=0. Combinational outputs are 0 while no request is present.
- Grant latency: 0 cycles (same cycle as request) in IDLE.
- Read latency: rd_gnt at T -> rd_valid_o/rd_data_o at T+1, high for exactly 1 cycle. No backpressure.
- Reads granted in the zeroize cycle complete at T+1 even though CLEAR has started.
- Zeroize: zeroize_i sampled at T; busy_o=1 for cycles T+1..T+DEPTH. Clear writes to addresses 0..DEPTH-1 occur in order. IDLE and grants are available again at T+DEPTH+1.
- rst_i mid-CLEAR: IDLE next cycle, busy_o=0, rd_valid_o=0. Array contents are undefined (partially cleared).
- Pointers are unchanged by cycles without a grant and by CLEAR.

## Test plan
- Write c0 addr 5, strobe 4'b0011, data 0xAABBCCDD over an all-zero word; read c1 addr 5 next cycle -> rd_valid_o=2'b10 one cycle after grant, rd_data_o=0x0000CCDD.
- Both clients request writes continuously for 4 cycles after reset -> wr_gnt_o sequence 01,10,01,10. Same check for reads with an independent pointer.
- Same-cycle write 0x11111111 and read at addr 3 (old value 0x22222222) -> read returns 0x22222222; a read the following cycle returns 0x11111111.
- zeroize_i pulse with DEPTH=64 and requests held throughout -> busy_o high exactly 64 cycles, no grants during that window, grants resume on cycle 65. Read-back of all addresses returns 0.
- Read granted in the zeroize cycle -> valid data on the next cycle. zeroize_i re-pulsed during CLEAR -> duration is unchanged.
- rst_i at clear counter=10 -> busy_o=0 next cycle, pointers back to 0, rd_valid_o=0; a new zeroize completes in full.
